cache_line_transfer: RTL and testbench

- Moves one full cache line between main memory and a dual_port_ram data array through a single RAM port.
- Fill: accepts a word stream from memory and writes it into the RAM line.
- Write-back: reads the RAM line and streams it out to memory.
- Sits between the cache controller/memory interface and the data-array port.

---
 rtl/cache_line_transfer.sv | 141 ++++++++++++++
 tb/tb_cache_line_transfer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_transfer.sv
// cache_line_transfer
//   Moves one cache line between main memory and a data-array RAM through a
//   single RAM port. A fill writes an incoming word stream into the line. A
//   write-back reads the line and streams it out to memory.
//
//   State  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a command, cmd_ready high
//   FILL   | accepting fill words, one RAM write per beat
//   WB_RD  | RAM read address presented for the current offset
//   WB_CAP | RAM read data valid, captured into wb_data
//   WB_SEND| wb word on offer until wb_ready
//   DONE   | one-cycle completion pulse
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_write_back, cmd_index direction (1 = RAM->memory) and line index
//   fill_valid/fill_ready     fill word handshake, fill_data payload
//   wb_valid/wb_ready         write-back word handshake, wb_data payload
//   ram_we, ram_address       RAM port control, address = {index, offset}
//   ram_data_in/ram_data_out  RAM write data / registered read data
//   busy, done                not-idle flag, one-cycle completion pulse
module cache_line_transfer #(
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 6,
    parameter int OFFSET_BITS   = 2,
    parameter int RAM_ADDR_BITS = INDEX_BITS + OFFSET_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write_back,
    input  logic [INDEX_BITS-1:0]    cmd_index,
    input  logic                     fill_valid,
    input  logic [DATA_WIDTH-1:0]    fill_data,
    output logic                     fill_ready,
    output logic                     wb_valid,
    output logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     wb_ready,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic                     busy,
    output logic                     done
);

    localparam int WORDS = 1 << OFFSET_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_OFFSET = OFFSET_BITS'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WB_RD,
        WB_CAP,
        WB_SEND,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   index_q, index_d;
    logic [OFFSET_BITS-1:0]  offset_q, offset_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    wb_valid_q, wb_valid_d;
    logic                    last_word;

    assign last_word = (offset_q == LAST_OFFSET);

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        offset_d   = offset_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = wb_valid_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    index_d  = cmd_index;
                    offset_d = '0;
                    state_d  = cmd_write_back ? WB_RD : FILL;
                end
            end
            FILL: begin
                if (fill_valid) begin
                    // Offset wraps inside its own field, so the line index never changes.
                    offset_d = offset_q + OFFSET_BITS'(1);
                    if (last_word) state_d = DONE;
                end
            end
            WB_RD: state_d = WB_CAP;
            WB_CAP: begin
                wb_data_d  = ram_data_out;
                wb_valid_d = 1'b1;
                state_d    = WB_SEND;
            end
            WB_SEND: begin
                if (wb_valid_q && wb_ready) begin
                    wb_valid_d = 1'b0;
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        offset_d = offset_q + OFFSET_BITS'(1);
                        state_d  = WB_RD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            offset_q   <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            offset_q   <= offset_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign fill_ready  = (state_q == FILL);
    // A fill beat is written on the cycle it is handed over; reset abandons it at once.
    assign ram_we      = (state_q == FILL) && fill_valid && !reset;
    assign ram_address = {index_q, offset_q};
    assign ram_data_in = fill_data;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_cache_line_transfer.sv
module tb_cache_line_transfer;

    localparam int DW = 32;
    localparam int IB = 6;
    localparam int OB = 2;
    localparam int AB = IB + OB;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write_back = 1'b0;
    logic [IB-1:0] cmd_index = '0;
    logic          fill_valid = 1'b0;
    logic [DW-1:0] fill_data = '0;
    logic          fill_ready;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic          wb_ready = 1'b0;
    logic          ram_we;
    logic [AB-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic          busy;
    logic          done;

    cache_line_transfer #(
        .DATA_WIDTH(DW), .INDEX_BITS(IB), .OFFSET_BITS(OB), .RAM_ADDR_BITS(AB)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write_back(cmd_write_back), .cmd_index(cmd_index),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready),
        .ram_we(ram_we), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Behavioural data array: registered read, one-cycle latency.
    logic [DW-1:0] ram_mem [0:(1<<AB)-1];
    logic [DW-1:0] ram_rd_q = '0;
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_address] <= ram_data_in;
        ram_rd_q <= ram_mem[ram_address];
    end
    assign ram_data_out = ram_rd_q;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [DW-1:0]    model [0:(1<<AB)-1];
    logic [AB+DW-1:0] exp_wr_q [$];
    logic [DW-1:0]    exp_wb_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every RAM write and every wb handshake must match
    // the head of its expectation queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (ram_we) begin
                chk("write_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    logic [AB+DW-1:0] e;
                    e = exp_wr_q.pop_front();
                    chk("write_addr", 64'(ram_address), 64'(e[AB+DW-1:DW]));
                    chk("write_data", 64'(ram_data_in), 64'(e[DW-1:0]));
                end
            end
            if (wb_valid && wb_ready) begin
                chk("wb_expected", 64'(exp_wb_q.size() != 0), 64'd1);
                if (exp_wb_q.size() != 0) chk("wb_data", 64'(wb_data), 64'(exp_wb_q.pop_front()));
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_fill(input int idx, input logic [DW-1:0] base,
                           input logic [15:0] pat, input int npat);
        int w;
        int d0;
        logic [AB-1:0] a;
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write_back = 1'b0; cmd_index = IB'(idx);
        step();
        cmd_valid = 1'b0;
        chk("fill_ready_in_fill", 64'(fill_ready), 64'd1);
        chk("busy_in_fill", 64'(busy), 64'd1);
        w = 0;
        for (int i = 0; i < npat; i++) begin
            fill_valid = pat[i];
            if (pat[i]) begin
                a = AB'(idx * 4 + w);
                fill_data = base + DW'(w);
                exp_wr_q.push_back({a, fill_data});
                model[a] = fill_data;
                w++;
            end else begin
                fill_data = 32'hDEAD_0000 + DW'(i);
            end
            step();
        end
        fill_valid = 1'b0;
        chk("fill_done_pulse", 64'(done), 64'd1);
        chk("fill_done_cmd_ready", 64'(cmd_ready), 64'd0);
        step();
        chk("fill_after_done", 64'(done), 64'd0);
        chk("fill_idle_ready", 64'(cmd_ready), 64'd1);
        chk("fill_writes_drained", 64'(exp_wr_q.size()), 64'd0);
        chk("fill_done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic do_wb(input int idx, input int stall_word, input int stall_n);
        int prev;
        int n;
        int d0;
        logic [AB-1:0] a;
        d0 = done_cnt;
        prev = 0;
        for (int w = 0; w < 4; w++) exp_wb_q.push_back(model[AB'(idx * 4 + w)]);
        cmd_valid = 1'b1; cmd_write_back = 1'b1; cmd_index = IB'(idx); wb_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (!wb_valid && n < 20) begin
                step();
                n++;
            end
            chk("wb_valid_seen", 64'(wb_valid), 64'd1);
            if (w > 0)
                chk("wb_spacing", 64'(cyc - prev), 64'(3 + ((w - 1 == stall_word) ? stall_n : 0)));
            prev = cyc;
            if (w == stall_word) begin
                a = AB'(idx * 4 + w);
                wb_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    chk("stall_wb_valid", 64'(wb_valid), 64'd1);
                    chk("stall_wb_data", 64'(wb_data), 64'(model[a]));
                    chk("stall_address", 64'(ram_address), 64'(a));
                end
                wb_ready = 1'b1;
            end
            step();
        end
        chk("wb_done_pulse", 64'(done), 64'd1);
        step();
        wb_ready = 1'b0;
        chk("wb_idle_ready", 64'(cmd_ready), 64'd1);
        chk("wb_drained", 64'(exp_wb_q.size()), 64'd0);
        chk("wb_done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < (1 << AB); i++) begin
            ram_mem[i] = '0;
            model[i]   = '0;
        end

        // Reset held for two cycles.
        for (int r = 0; r < 2; r++) begin
            step();
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_ram_we", 64'(ram_we), 64'd0);
            chk("rst_address", 64'(ram_address), 64'd0);
            chk("rst_fill_ready", 64'(fill_ready), 64'd0);
            chk("rst_wb_valid", 64'(wb_valid), 64'd0);
            chk("rst_wb_data", 64'(wb_data), 64'd0);
        end
        reset = 1'b0;
        step();
        chk("rst_no_done", 64'(done_cnt), 64'd0);

        // Fill line 5, no stalls: addresses 20..23.
        do_fill(5, 32'hA0, 16'b1111, 4);
        // Fill line 9 with gaps 1,0,0,1,1,0,1.
        do_fill(9, 32'hB0, 16'b1011001, 7);
        // Write-back line 5, wb_ready always high.
        do_wb(5, -1, 0);
        // Write-back line 5 with word 2 held off for 5 cycles.
        do_wb(5, 2, 5);
        // Write-back line 9 to confirm gapped fill contents.
        do_wb(9, -1, 0);

        // Fill line 63, reset after the second word.
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write_back = 1'b0; cmd_index = IB'(63);
        step();
        cmd_valid = 1'b0;
        for (int w = 0; w < 2; w++) begin
            fill_valid = 1'b1;
            fill_data  = 32'hC0 + DW'(w);
            exp_wr_q.push_back({AB'(252 + w), fill_data});
            model[AB'(252 + w)] = fill_data;
            step();
        end
        fill_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_address", 64'(ram_address), 64'd0);
        step();
        step();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_writes", 64'(exp_wr_q.size()), 64'd0);
        chk("abort_ram_252", 64'(ram_mem[252]), 64'hC0);
        chk("abort_ram_253", 64'(ram_mem[253]), 64'hC1);

        // Refill line 63: 252..255, never wraps to address 0.
        do_fill(63, 32'hD0, 16'b1111, 4);
        chk("no_write_addr0", 64'(ram_mem[0]), 64'd0);
        do_wb(63, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
